// File: rtl/dispatch_rename_pkg.sv
// Shared widths, register-status-table entry and dispatch packet types for the rename stage.
package dispatch_rename_pkg;

    localparam int unsigned TAG_WIDTH       = 6;
    localparam int unsigned REG_ADDR_WIDTH  = 5;
    localparam int unsigned NUM_ARCH_REGS   = 32;
    localparam int unsigned RST_ENTRY_WIDTH = 1 + TAG_WIDTH;

    typedef struct packed {
        logic                 pending;
        logic [TAG_WIDTH-1:0] tag;
    } rst_entry_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] rs_tag;
        logic                 rs_ready;
        logic [TAG_WIDTH-1:0] rt_tag;
        logic                 rt_ready;
        logic [TAG_WIDTH-1:0] rd_tag;
        logic                 rd_write;
    } disp_pkt_t;

    // A source is ready if nothing is pending on it or its producer is on the CDB right now.
    function automatic logic src_ready(input rst_entry_t e, input logic cdb_valid,
                                       input logic [TAG_WIDTH-1:0] cdb_tag);
        return !e.pending || (cdb_valid && (cdb_tag == e.tag));
    endfunction

endpackage

// File: rtl/dispatch_rename_rst_entry.sv
// One register-status-table entry: holds {pending, tag} and clears itself on a matching CDB tag.
module rst_entry
    import dispatch_rename_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 wr_en_i,
    input  logic [TAG_WIDTH-1:0] wr_tag_i,
    input  logic [TAG_WIDTH-1:0] cdb_tag_i,
    input  logic                 cdb_valid_i,
    output rst_entry_t           entry_o
);

    rst_entry_t entry_q, entry_d;

    // Flush beats a new mapping, and a new mapping beats a CDB clear of the old one.
    always_comb begin
        entry_d = entry_q;
        if (flush_i) begin
            entry_d = '0;
        end else if (wr_en_i) begin
            entry_d.pending = 1'b1;
            entry_d.tag     = wr_tag_i;
        end else if (cdb_valid_i && entry_q.pending && (cdb_tag_i == entry_q.tag)) begin
            entry_d.pending = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/dispatch_rename.sv
// Rename/dispatch stage: source lookup in the RST, free-tag pop for the destination, registered packet out.
module dispatch_rename #(
    parameter int unsigned TAG_WIDTH      = dispatch_rename_pkg::TAG_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = dispatch_rename_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      disp_valid,
    input  logic [REG_ADDR_WIDTH-1:0] disp_rs,
    input  logic [REG_ADDR_WIDTH-1:0] disp_rt,
    input  logic [REG_ADDR_WIDTH-1:0] disp_rd,
    input  logic                      disp_reg_write,
    input  logic                      iq_full,
    input  logic                      ef_tf,
    input  logic [TAG_WIDTH-1:0]      tagout_tf,
    output logic                      ren_tf,
    input  logic [TAG_WIDTH-1:0]      cdb_tag,
    input  logic                      cdb_valid,
    output logic                      disp_ready,
    output logic                      out_valid,
    output logic [TAG_WIDTH-1:0]      out_rs_tag,
    output logic [TAG_WIDTH-1:0]      out_rt_tag,
    output logic                      out_rs_ready,
    output logic                      out_rt_ready,
    output logic [TAG_WIDTH-1:0]      out_rd_tag,
    output logic                      out_rd_write
);
    import dispatch_rename_pkg::*;

    localparam int unsigned NUM_ENTRIES = 2 ** REG_ADDR_WIDTH;

    logic       wr;
    logic       fire;
    rst_entry_t rst_tbl [NUM_ENTRIES];
    rst_entry_t rs_ent, rt_ent;
    disp_pkt_t  pkt_d, pkt_q;

    // Register 0 is hard-wired, so it never consumes a tag.
    assign wr         = disp_reg_write && (disp_rd != '0);
    assign disp_ready = !reset && !iq_full && !(wr && ef_tf) && !flush;
    assign fire       = disp_valid && disp_ready;
    assign ren_tf     = fire && wr;

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_rst
        rst_entry u_entry (
            .clk         (clk),
            .reset       (reset),
            .flush_i     (flush),
            .wr_en_i     (ren_tf && (disp_rd == REG_ADDR_WIDTH'(i))),
            .wr_tag_i    (tagout_tf),
            .cdb_tag_i   (cdb_tag),
            .cdb_valid_i (cdb_valid),
            .entry_o     (rst_tbl[i])
        );
    end

    // Lookups see the mapping before this cycle's destination write.
    always_comb begin
        rs_ent = rst_tbl[disp_rs];
        rt_ent = rst_tbl[disp_rt];
        if (disp_rs == '0) rs_ent = '0;
        if (disp_rt == '0) rt_ent = '0;
    end

    always_comb begin
        pkt_d = '0;
        if (fire) begin
            pkt_d.valid    = 1'b1;
            pkt_d.rs_tag   = rs_ent.tag;
            pkt_d.rs_ready = src_ready(rs_ent, cdb_valid, cdb_tag);
            pkt_d.rt_tag   = rt_ent.tag;
            pkt_d.rt_ready = src_ready(rt_ent, cdb_valid, cdb_tag);
            pkt_d.rd_tag   = wr ? tagout_tf : '0;
            pkt_d.rd_write = wr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_q <= '0;
        end else if (flush) begin
            pkt_q <= '0;
        end else begin
            pkt_q <= pkt_d;
        end
    end

    assign out_valid    = pkt_q.valid;
    assign out_rs_tag   = pkt_q.rs_tag;
    assign out_rs_ready = pkt_q.rs_ready;
    assign out_rt_tag   = pkt_q.rt_tag;
    assign out_rt_ready = pkt_q.rt_ready;
    assign out_rd_tag   = pkt_q.rd_tag;
    assign out_rd_write = pkt_q.rd_write;

endmodule

// File: tb/tb_dispatch_rename.sv
// Directed bench for dispatch_rename: driver queues expected packets, a negedge monitor pops and compares.
module tb_dispatch_rename;

    logic       clk = 1'b0;
    logic       reset, flush, disp_valid, disp_reg_write, iq_full, ef_tf, cdb_valid;
    logic [4:0] disp_rs, disp_rt, disp_rd;
    logic [5:0] tagout_tf, cdb_tag;
    logic       ren_tf, disp_ready, out_valid, out_rs_ready, out_rt_ready, out_rd_write;
    logic [5:0] out_rs_tag, out_rt_tag, out_rd_tag;

    typedef struct packed {
        logic [5:0] rs_tag;
        logic       rs_ready;
        logic [5:0] rt_tag;
        logic       rt_ready;
        logic [5:0] rd_tag;
        logic       rd_write;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    dispatch_rename dut (
        .clk(clk), .reset(reset), .flush(flush), .disp_valid(disp_valid),
        .disp_rs(disp_rs), .disp_rt(disp_rt), .disp_rd(disp_rd),
        .disp_reg_write(disp_reg_write), .iq_full(iq_full), .ef_tf(ef_tf),
        .tagout_tf(tagout_tf), .ren_tf(ren_tf), .cdb_tag(cdb_tag), .cdb_valid(cdb_valid),
        .disp_ready(disp_ready), .out_valid(out_valid),
        .out_rs_tag(out_rs_tag), .out_rt_tag(out_rt_tag),
        .out_rs_ready(out_rs_ready), .out_rt_ready(out_rt_ready),
        .out_rd_tag(out_rd_tag), .out_rd_write(out_rd_write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; applies one cycle of inputs and returns just after the next edge.
    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic rw, input logic iqf, input logic ef,
                        input logic [5:0] tag, input logic cv, input logic [5:0] ct, input logic fl,
                        input logic e_rdy, input logic e_ren,
                        input logic [5:0] e_rs_tag, input logic e_rs_rdy,
                        input logic [5:0] e_rt_tag, input logic e_rt_rdy,
                        input logic [5:0] e_rd_tag, input logic e_rd_wr);
        disp_valid = v; disp_rs = rs; disp_rt = rt; disp_rd = rd; disp_reg_write = rw;
        iq_full = iqf; ef_tf = ef; tagout_tf = tag; cdb_valid = cv; cdb_tag = ct; flush = fl;
        #1;
        chk("disp_ready", int'(disp_ready), int'(e_rdy));
        chk("ren_tf", int'(ren_tf), int'(e_ren));
        if (v && e_rdy)
            exp_q.push_back(exp_t'{e_rs_tag, e_rs_rdy, e_rt_tag, e_rt_rdy, e_rd_tag, e_rd_wr});
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented packet must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_packet: out_valid=1 with no packet expected (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_rs_tag", int'(out_rs_tag), int'(mon_e.rs_tag));
                chk("out_rs_ready", int'(out_rs_ready), int'(mon_e.rs_ready));
                chk("out_rt_tag", int'(out_rt_tag), int'(mon_e.rt_tag));
                chk("out_rt_ready", int'(out_rt_ready), int'(mon_e.rt_ready));
                chk("out_rd_tag", int'(out_rd_tag), int'(mon_e.rd_tag));
                chk("out_rd_write", int'(out_rd_write), int'(mon_e.rd_write));
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; disp_valid = 1'b1; disp_rs = 5'd1; disp_rt = 5'd2;
        disp_rd = 5'd3; disp_reg_write = 1'b1; iq_full = 1'b0; ef_tf = 1'b0;
        tagout_tf = 6'd5; cdb_valid = 1'b0; cdb_tag = 6'd0;
        #2;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_rd_tag", int'(out_rd_tag), 0);
        chk("reset_disp_ready", int'(disp_ready), 0);
        chk("reset_ren_tf", int'(ren_tf), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // add r3,r1,r2 takes tag 5
        step(1, 1, 2, 3, 1, 0, 0, 5, 0, 0, 0,  1, 1,  0, 1, 0, 1, 5, 1);
        // reader of r3 without CDB, then with CDB tag 5, then after the clear
        step(1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0,  5, 0, 0, 1, 0, 0);
        step(1, 3, 3, 0, 0, 0, 0, 0, 1, 5, 0,  1, 0,  5, 1, 5, 1, 0, 0);
        step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0,  0, 1, 5, 1, 0, 0);
        // empty tag FIFO: a writer stalls, a non-writer dispatches without a pop
        step(1, 1, 2, 4, 1, 0, 1, 6, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
        step(1, 4, 3, 4, 0, 0, 1, 6, 0, 0, 0,  1, 0,  0, 1, 5, 1, 0, 0);
        // issue queue full stalls
        step(1, 1, 2, 8, 1, 1, 0, 6, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
        // rd=0 writer is not renamed and leaves r0 untouched
        step(1, 0, 0, 0, 1, 0, 0, 12, 0, 0, 0, 1, 0,  0, 1, 0, 1, 0, 0);
        step(1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0,  0, 1, 0, 1, 0, 0);
        // r7 gets tag 2, then is renamed to 9 while CDB broadcasts 2
        step(1, 1, 2, 7, 1, 0, 0, 2, 0, 0, 0,  1, 1,  0, 1, 0, 1, 2, 1);
        step(1, 7, 0, 7, 1, 0, 0, 9, 1, 2, 0,  1, 1,  2, 1, 0, 1, 9, 1);
        step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0,  0, 1, 9, 0, 0, 0);
        // idle cycle clears r7 via CDB 9; tag is held
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0,  1, 0,  0, 0, 0, 0, 0, 0);
        step(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0,  9, 1, 0, 1, 0, 0);
        // back-to-back allocations r1..r5 take tags 10..14
        for (int i = 1; i <= 5; i++)
            step(1, 5'(i - 1), 0, 5'(i), 1, 0, 0, 6'(9 + i), 0, 0, 0,  1, 1,
                 (i == 1) ? 6'd0 : 6'(8 + i), logic'(i == 1), 0, 1, 6'(9 + i), 1);
        // flush with a valid writer: no accept, no pop
        step(1, 1, 2, 6, 1, 0, 0, 15, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0,  0, 1, 0, 1, 0, 0);
        step(1, 3, 5, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0,  0, 1, 0, 1, 0, 0);
        step(1, 7, 4, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0,  0, 1, 0, 1, 0, 0);

        // async reset right after a dispatch edge wipes the packet and the new mapping
        disp_valid = 1'b1; disp_rs = 5'd1; disp_rt = 5'd2; disp_rd = 5'd2;
        disp_reg_write = 1'b1; tagout_tf = 6'd20; cdb_valid = 1'b0; flush = 1'b0;
        #1;
        chk("pre_reset_ren_tf", int'(ren_tf), 1);
        @(posedge clk);
        #1;
        chk("pre_reset_out_valid", int'(out_valid), 1);
        reset = 1'b1;
        #1;
        chk("async_reset_out_valid", int'(out_valid), 0);
        chk("async_reset_out_rd_tag", int'(out_rd_tag), 0);
        chk("async_reset_out_rd_write", int'(out_rd_write), 0);
        chk("async_reset_disp_ready", int'(disp_ready), 0);
        chk("async_reset_ren_tf", int'(ren_tf), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0,  0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0,  0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        chk("pending_packets", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dispatch_rename.md
# dispatch_rename

Rename-and-dispatch stage of the dispatch unit, directly downstream of the tag FIFO (free-tag source). Each cycle it accepts at most one decoded instruction and reads source-operand mappings from a 32-entry register status table (RST). It pops a free tag from the tag FIFO for the destination and issues a registered dispatch packet toward the issue queues. CDB broadcasts clear RST entries; flush empties the table.

## Interface
Parameters:
- TAG_WIDTH, 6, tag width; matches the tag FIFO.
- REG_ADDR_WIDTH, 5, architectural register index width; the RST has 2**REG_ADDR_WIDTH entries.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous; clears RST and output packet.
- disp_valid  in  1  decoded instruction present.
- disp_rs  in  REG_ADDR_WIDTH  source 1 register.
- disp_rt  in  REG_ADDR_WIDTH  source 2 register.
- disp_rd  in  REG_ADDR_WIDTH  destination register.
- disp_reg_write  in  1  instruction writes disp_rd.
- iq_full  in  1  downstream issue queue cannot accept.
- ef_tf  in  1  tag FIFO empty.
- tagout_tf  in  TAG_WIDTH  tag at FIFO head (combinational).
- ren_tf  out  1  pop FIFO head this cycle.
- cdb_tag  in  TAG_WIDTH  completing tag.
- cdb_valid  in  1  cdb_tag valid.
- disp_ready  out  1  instruction accepted this cycle if disp_valid.
- out_valid  out  1  dispatch packet valid.
- out_rs_tag, out_rt_tag  out  TAG_WIDTH  producer tags of sources.
- out_rs_ready, out_rt_ready  out  1  source value available in register file.
- out_rd_tag  out  TAG_WIDTH  tag allocated for destination.
- out_rd_write  out  1  destination renamed.

## Operation
- RST entry: {pending, tag}. pending=1: register awaits that tag.
- Effective write: wr = disp_reg_write && (disp_rd != 0). Register 0 is never renamed; it always reads ready, tag 0.
- Stall: disp_ready = !iq_full && !(wr && ef_tf) && !flush.
- Fire: fire = disp_valid && disp_ready. ren_tf = fire && wr, combinational, same cycle.
- Source lookup: tag = RST[rs].tag; ready = !RST[rs].pending || (cdb_valid && cdb_tag == RST[rs].tag). Same for rt. Lookup uses the pre-dispatch mapping, so rs == rd yields the old producer.
- On fire && wr: RST[rd] <= {1, tagout_tf}.
- CDB: every entry with pending && tag == cdb_tag is cleared (pending <= 0; tag is held).
- Same-cycle dispatch write and CDB match on the same entry: the dispatch write wins, and the entry stays pending on the new tag.
- Flush: all pending <= 0, tags <= 0, out_valid <= 0. Flush has priority over fire and CDB. ren_tf is 0 during flush.
- Reset: same as flush, applied asynchronously. All outputs are 0 during reset, except ren_tf and disp_ready, which are 0 while reset is high.

## Timing
- Lookup to packet: 1-cycle latency. Inputs sampled at edge N appear on the out_* signals after edge N.
- out_valid <= fire every cycle; a packet is held for one cycle only. iq_full is checked before fire, so there is no output backpressure.
- ren_tf and the RST write share the same edge. The FIFO read pointer advances on that edge, and the next head tag is usable the following cycle. Back-to-back allocations take consecutive tags.
- CDB clear is visible to the next cycle's lookups; same-cycle visibility is provided by the ready bypass.
- ef_tf=1 with wr=0: the instruction dispatches and no pop occurs.

## Structure
- Shared package: TAG_WIDTH, REG_ADDR_WIDTH, NUM_ARCH_REGS = 32, and an RST-entry struct/width constant (1 + TAG_WIDTH).
- Sub-module rst_entry is instantiated 32× via generate. Per entry:
  - holds pending/tag;
  - inputs: write enable, write tag, CDB tag/valid, flush, clk, reset;
  - performs its own CDB compare.
- The top level holds the read muxes, stall logic and the output packet register.

## Test plan
- Reset, then dispatch add r3,r1,r2 with head tag 5:
  - ren_tf=1 that cycle;
  - next cycle out_valid=1, rs/rt ready=1, out_rd_tag=5;
  - RST[3] pending on 5.
- Dispatch a reader of r3 next cycle with cdb_valid=1, cdb_tag=5 in the same cycle:
  - out_rs_tag=5, out_rs_ready=1.
  - Repeat without CDB: out_rs_ready=0.
- ef_tf=1 with disp_reg_write=1, rd=4: disp_ready=0, ren_tf=0, out_valid=0 next cycle. With disp_reg_write=0: dispatches.
- rd=0 with disp_reg_write=1: ren_tf=0, out_rd_write=0, RST unchanged.
- Dispatch writes r7 (head tag 9) while CDB broadcasts r7's old tag 2: RST[7] ends {pending=1, tag=9}.
- Fill r1..r5 pending, then assert flush with disp_valid=1:
  - ren_tf=0;
  - next cycle out_valid=0;
  - all sources read ready.
  - Async reset mid-dispatch clears out_valid immediately.
